miner_result_collector: RTL
===========================

// Module: miner_result_collector
// PURPOSE
// - Consumer end of the nonce path. Drives the nonce counter (clear/count_enable), receives hash-core results
//   (nonce + 256-bit hash), and flags a winner when hash <= target.
// - Drains in-flight results after the counter wraps, then reports a golden nonce or "exhausted" to the
//   host interface over a valid/ack handshake. Sits between miner_NonceCounter and the host register block.
// PARAMETERS
// - NONCE_BITS  32   width of nonce / counter value
// - HASH_BITS   256  width of hash_value and target
// - HASH_LAT    64   hash-core latency (cycles) from count_out to hash_valid; sets drain length
// PORTS
// - clk              in   1           clock
// - n_rst            in   1           reset, asynchronous, active-low
// - start            in   1           pulse: begin new search (honoured in IDLE only)
// - abort            in   1           sync abort: return to IDLE from any state
// - target           in   HASH_BITS   difficulty target, stable while busy
// - hash_valid       in   1           hash-core result strobe
// - hash_nonce       in   NONCE_BITS  nonce belonging to hash_value
// - hash_value       in   HASH_BITS   hash-core result
// - counter_rollover in   1           nonce counter rollover_flag (last nonce issued)
// - rd_ack           in   1           host accepted found_valid/exhausted
// - counter_clear    out  1           to nonce counter clear
// - count_enable     out  1           to nonce counter count_enable
// - busy             out  1           state != IDLE
// - found_valid      out  1           golden nonce available
// - found_nonce      out  NONCE_BITS  golden nonce
// - exhausted        out  1           nonce space done, no hit
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 incl. found_nonce; compare stage and drain counter cleared.
// - States: IDLE, CLEAR, SEARCH, DRAIN, REPORT, EXHAUST. All outputs are Moore (decoded from registered state).
// - Compare stage (1-cycle latency): hit_q <= hash_valid & (hash_value <= target), unsigned full-width;
//   nonce_q <= hash_nonce. hit_q is ignored in IDLE, CLEAR, REPORT and EXHAUST (dropped, no side effect).
// - IDLE: start=1 -> CLEAR.
// - CLEAR: counter_clear=1 for exactly 1 cycle -> SEARCH.
// - SEARCH: count_enable=1. hit_q -> latch found_nonce<=nonce_q, go REPORT. Else counter_rollover ->
//   load drain_cnt<=HASH_LAT+1, go DRAIN. Hit and rollover in the same cycle: hit wins.
// - Counter may advance 1 extra step after a hit (Moore enable); this is allowed.
// - DRAIN: count_enable=0; hit_q -> latch nonce, REPORT; else drain_cnt decrements; drain_cnt==0 -> EXHAUST.
//   drain_cnt width $clog2(HASH_LAT+2); it never wraps.
// - REPORT: found_valid=1, found_nonce held; rd_ack -> IDLE (found_valid drops the next cycle,
//   found_nonce retains its value until the next latch).
// - EXHAUST: exhausted=1; rd_ack -> IDLE.
// - abort=1: next state IDLE from any state, overriding all other transitions; found_valid/exhausted drop.
// - rd_ack outside REPORT/EXHAUST: ignored. start outside IDLE: ignored.
// - Async reset mid-operation: immediate IDLE, outputs 0; the counter is re-cleared on the next start.
// STRUCTURE
// - miner_pkg: typedef enum logic [2:0] collector_state_t; localparams NONCE_BITS=32, HASH_BITS=256.
// - Sub-module miner_target_cmp: registered hash<=target comparator + nonce_q pipeline register
//   (isolates the 256-bit compare for timing).
// - Top: state register, next-state logic, drain counter, found_nonce register.
// TESTING
// - Reset, then start: counter_clear high exactly 1 cycle, then count_enable=1; busy=1 from the cycle after start.
// - Hit: target=2^255, hash_valid with hash=0x1, nonce=0x00000ABC in SEARCH -> 2 cycles later found_valid=1,
//   found_nonce=0x00000ABC; rd_ack -> IDLE, found_valid=0 next cycle.
// - Boundary: hash==target -> hit; hash==target+1 -> no hit.
// - Exhaust: HASH_LAT=4, counter_rollover in SEARCH, no hits -> count_enable=0, exhausted=1 after 6 cycles;
//   a hit injected during DRAIN -> REPORT with that nonce instead.
// - Same-cycle hit_q and counter_rollover -> REPORT, not DRAIN; a second hit during REPORT leaves found_nonce
//   unchanged.
// - abort in SEARCH and in REPORT -> IDLE next cycle, all flags 0; n_rst pulse mid-DRAIN -> IDLE, outputs 0.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and default widths for the miner nonce/result path.
package miner_pkg;

    localparam int unsigned NONCE_BITS = 32;
    localparam int unsigned HASH_BITS  = 256;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StSearch  = 3'd2,
        StDrain   = 3'd3,
        StReport  = 3'd4,
        StExhaust = 3'd5
    } collector_state_t;

endpackage

// File: rtl/miner_target_cmp.sv
// Registered hash <= target comparator with its matching nonce pipeline register;
// keeps the wide compare in a stage of its own.
module miner_target_cmp
    import miner_pkg::*;
#(
    parameter int unsigned NONCE_W = NONCE_BITS,
    parameter int unsigned HASH_W  = HASH_BITS
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_hash_valid,
    input  logic [NONCE_W-1:0] i_hash_nonce,
    input  logic [HASH_W-1:0]  i_hash_value,
    input  logic [HASH_W-1:0]  i_target,
    output logic               o_hit,
    output logic [NONCE_W-1:0] o_nonce
);

    logic               r_hit;
    logic [NONCE_W-1:0] r_nonce;
    logic               w_le;

    assign w_le = (i_hash_value <= i_target);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_hit   <= 1'b0;
            r_nonce <= '0;
        end else begin
            r_hit   <= i_hash_valid & w_le;
            r_nonce <= i_hash_nonce;
        end
    end

    assign o_hit   = r_hit;
    assign o_nonce = r_nonce;

endmodule

// File: rtl/miner_result_collector.sv
// Consumer end of the nonce path: sequences the nonce counter, collects hash-core results and
// reports either a golden nonce or exhaustion of the nonce space to the host.
module miner_result_collector
    import miner_pkg::*;
#(
    parameter int unsigned NONCE_W  = NONCE_BITS,
    parameter int unsigned HASH_W   = HASH_BITS,
    parameter int unsigned HASH_LAT = 64
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [HASH_W-1:0]  i_target,
    input  logic               i_hash_valid,
    input  logic [NONCE_W-1:0] i_hash_nonce,
    input  logic [HASH_W-1:0]  i_hash_value,
    input  logic               i_counter_rollover,
    input  logic               i_rd_ack,
    output logic               o_counter_clear,
    output logic               o_count_enable,
    output logic               o_busy,
    output logic               o_found_valid,
    output logic [NONCE_W-1:0] o_found_nonce,
    output logic               o_exhausted
);

    localparam int unsigned DRAIN_W = $clog2(HASH_LAT + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(HASH_LAT + 1);

    collector_state_t   r_state;
    collector_state_t   w_state_d;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [NONCE_W-1:0] r_found_nonce;

    logic               w_hit;
    logic [NONCE_W-1:0] w_cmp_nonce;
    logic               w_latch;
    logic               w_drain_load;
    logic               w_drain_dec;

    miner_target_cmp #(
        .NONCE_W (NONCE_W),
        .HASH_W  (HASH_W)
    ) u_target_cmp (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_hash_valid (i_hash_valid),
        .i_hash_nonce (i_hash_nonce),
        .i_hash_value (i_hash_value),
        .i_target     (i_target),
        .o_hit        (w_hit),
        .o_nonce      (w_cmp_nonce)
    );

    always_comb begin
        w_state_d    = r_state;
        w_latch      = 1'b0;
        w_drain_load = 1'b0;
        w_drain_dec  = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) w_state_d = StClear;
            end
            StClear: begin
                w_state_d = StSearch;
            end
            StSearch: begin
                if (w_hit) begin
                    w_state_d = StReport;
                    w_latch   = 1'b1;
                end else if (i_counter_rollover) begin
                    w_state_d    = StDrain;
                    w_drain_load = 1'b1;
                end
            end
            StDrain: begin
                if (w_hit) begin
                    w_state_d = StReport;
                    w_latch   = 1'b1;
                end else if (r_drain_cnt == '0) begin
                    w_state_d = StExhaust;
                end else begin
                    w_drain_dec = 1'b1;
                end
            end
            StReport: begin
                if (i_rd_ack) w_state_d = StIdle;
            end
            StExhaust: begin
                if (i_rd_ack) w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        if (i_abort) begin
            w_state_d    = StIdle;
            w_latch      = 1'b0;
            w_drain_load = 1'b0;
            w_drain_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Drain window covers the last issued nonce's trip through the core plus the compare stage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_drain_cnt <= '0;
        end else if (w_drain_load) begin
            r_drain_cnt <= DRAIN_LOAD;
        end else if (w_drain_dec) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_found_nonce <= '0;
        end else if (w_latch) begin
            r_found_nonce <= w_cmp_nonce;
        end
    end

    assign o_counter_clear = (r_state == StClear);
    assign o_count_enable  = (r_state == StSearch);
    assign o_busy          = (r_state != StIdle);
    assign o_found_valid   = (r_state == StReport);
    assign o_exhausted     = (r_state == StExhaust);
    assign o_found_nonce   = r_found_nonce;

endmodule
